// File: rtl/rv_fetch_align.sv
//==============================================================================
// Module      : rv_fetch_align
// Description : Fetch-word to instruction aligner with optional RVC support.
//               Define RV_EXT_C_EN to enable the halfword buffer and the
//               compressed-instruction expander.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

`ifdef RV_EXT_C_EN
module rv_fetch_align_rvc (
    input  logic [15:0] i_c,
    output logic [31:0] o_instr,
    output logic        o_illegal
);
    logic [4:0] w_rd;
    logic [4:0] w_rs2;
    logic [4:0] w_rdp;
    logic [4:0] w_rs1p;
    logic       w_c12;

    assign w_rd   = i_c[11:7];
    assign w_rs2  = i_c[6:2];
    assign w_rdp  = {2'b01, i_c[4:2]};
    assign w_rs1p = {2'b01, i_c[9:7]};
    assign w_c12  = i_c[12];

    always_comb begin
        o_instr   = 32'h0;
        o_illegal = 1'b0;
        case (i_c[1:0])
            2'b00: begin
                case (i_c[15:13])
                    3'b000: begin
                        o_instr   = {2'b00, i_c[10:7], i_c[12:11], i_c[5], i_c[6], 2'b00,
                                     5'd2, 3'b000, w_rdp, 7'b0010011};
                        o_illegal = (i_c[12:5] == 8'h00);
                    end
                    3'b010:  o_instr = {5'b0, i_c[5], i_c[12:10], i_c[6], 2'b00,
                                        w_rs1p, 3'b010, w_rdp, 7'b0000011};
                    3'b110:  o_instr = {5'b0, i_c[5], i_c[12], w_rdp, w_rs1p, 3'b010,
                                        i_c[11:10], i_c[6], 2'b00, 7'b0100011};
                    default: o_illegal = 1'b1;
                endcase
            end
            2'b01: begin
                case (i_c[15:13])
                    3'b000: o_instr = {{7{w_c12}}, i_c[6:2], w_rd, 3'b000, w_rd, 7'b0010011};
                    3'b001, 3'b101: begin
                        o_instr = {w_c12, i_c[8], i_c[10:9], i_c[6], i_c[7], i_c[2], i_c[11],
                                   i_c[5:3], w_c12, {8{w_c12}},
                                   (i_c[15] ? 5'd0 : 5'd1), 7'b1101111};
                    end
                    3'b010: o_instr = {{7{w_c12}}, i_c[6:2], 5'd0, 3'b000, w_rd, 7'b0010011};
                    3'b011: begin
                        o_illegal = ({w_c12, i_c[6:2]} == 6'd0);
                        if (w_rd == 5'd2)
                            o_instr = {{3{w_c12}}, i_c[4:3], i_c[5], i_c[2], i_c[6], 4'b0000,
                                       5'd2, 3'b000, 5'd2, 7'b0010011};
                        else
                            o_instr = {{15{w_c12}}, i_c[6:2], w_rd, 7'b0110111};
                    end
                    3'b100: begin
                        case (i_c[11:10])
                            2'b00: begin
                                o_instr   = {7'b0000000, i_c[6:2], w_rs1p, 3'b101, w_rs1p, 7'b0010011};
                                o_illegal = w_c12;
                            end
                            2'b01: begin
                                o_instr   = {7'b0100000, i_c[6:2], w_rs1p, 3'b101, w_rs1p, 7'b0010011};
                                o_illegal = w_c12;
                            end
                            2'b10: o_instr = {{7{w_c12}}, i_c[6:2], w_rs1p, 3'b111, w_rs1p, 7'b0010011};
                            default: begin
                                o_illegal = w_c12;
                                case (i_c[6:5])
                                    2'b00:   o_instr = {7'b0100000, w_rdp, w_rs1p, 3'b000, w_rs1p, 7'b0110011};
                                    2'b01:   o_instr = {7'b0000000, w_rdp, w_rs1p, 3'b100, w_rs1p, 7'b0110011};
                                    2'b10:   o_instr = {7'b0000000, w_rdp, w_rs1p, 3'b110, w_rs1p, 7'b0110011};
                                    default: o_instr = {7'b0000000, w_rdp, w_rs1p, 3'b111, w_rs1p, 7'b0110011};
                                endcase
                            end
                        endcase
                    end
                    default: begin
                        o_instr = {{4{w_c12}}, i_c[6:5], i_c[2], 5'd0, w_rs1p, {2'b00, i_c[13]},
                                   i_c[11:10], i_c[4:3], w_c12, 7'b1100011};
                    end
                endcase
            end
            2'b10: begin
                case (i_c[15:13])
                    3'b000: begin
                        o_instr   = {7'b0000000, i_c[6:2], w_rd, 3'b001, w_rd, 7'b0010011};
                        o_illegal = w_c12;
                    end
                    3'b010: begin
                        o_instr   = {4'b0000, i_c[3:2], w_c12, i_c[6:4], 2'b00,
                                     5'd2, 3'b010, w_rd, 7'b0000011};
                        o_illegal = (w_rd == 5'd0);
                    end
                    3'b100: begin
                        if (!w_c12) begin
                            if (w_rs2 == 5'd0) begin
                                o_instr   = {12'h000, w_rd, 3'b000, 5'd0, 7'b1100111};
                                o_illegal = (w_rd == 5'd0);
                            end else begin
                                o_instr = {7'b0000000, w_rs2, 5'd0, 3'b000, w_rd, 7'b0110011};
                            end
                        end else if (w_rs2 == 5'd0 && w_rd == 5'd0) begin
                            o_instr = 32'h00100073;
                        end else if (w_rs2 == 5'd0) begin
                            o_instr = {12'h000, w_rd, 3'b000, 5'd1, 7'b1100111};
                        end else begin
                            o_instr = {7'b0000000, w_rs2, w_rd, 3'b000, w_rd, 7'b0110011};
                        end
                    end
                    3'b110:  o_instr = {4'b0000, i_c[8:7], w_c12, w_rs2, 5'd2, 3'b010,
                                        i_c[11:9], 2'b00, 7'b0100011};
                    default: o_illegal = 1'b1;
                endcase
            end
            default: o_illegal = 1'b1;
        endcase
    end
endmodule
`endif

module rv_fetch_align (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_flush,
    input  logic [31:0] i_flush_pc,
    output logic [31:0] o_fetch_addr,
    input  logic        i_mem_valid,
    input  logic [31:0] i_mem_data,
    output logic        o_mem_ready,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    output logic        o_instr_comp,
    output logic        o_instr_illegal
);
    logic [31:0] r_fetch_addr;
    logic [31:0] r_head_pc;
    logic        r_out_valid;
    logic [31:0] r_out_instr;
    logic [31:0] r_out_pc;
    logic        r_out_comp;
    logic        r_out_ill;

    logic        w_avail;
    logic        w_load;
    logic        w_accept;
    logic [31:0] w_nxt_instr;
    logic        w_nxt_comp;
    logic        w_nxt_ill;
    logic [2:0]  w_pop_bytes;
    logic [31:0] w_flush_head;

    assign w_load = w_avail & (~r_out_valid | i_instr_ready);

`ifdef RV_EXT_C_EN
    logic [47:0] r_buf;
    logic [1:0]  r_hw_cnt;
    logic        r_skip;
    logic [15:0] w_head;
    logic        w_head_is32;
    logic [1:0]  w_pop;
    logic [1:0]  w_cnt_left;
    logic [47:0] w_buf_left;
    logic [47:0] w_buf_nxt;
    logic [1:0]  w_cnt_nxt;
    logic [31:0] w_app_data;
    logic [1:0]  w_app_n;
    logic [31:0] w_exp_instr;
    logic        w_exp_ill;
    logic        w_unused_pc0;

    assign w_head       = r_buf[15:0];
    assign w_head_is32  = &w_head[1:0];
    assign w_avail      = w_head_is32 ? (r_hw_cnt >= 2'd2) : (r_hw_cnt >= 2'd1);
    assign w_pop        = w_load ? (w_head_is32 ? 2'd2 : 2'd1) : 2'd0;
    assign w_cnt_left   = r_hw_cnt - w_pop;
    assign o_mem_ready  = ~i_reset & ~i_flush & (w_cnt_left <= 2'd1);
    assign w_accept     = i_mem_valid & o_mem_ready;
    assign w_flush_head = {i_flush_pc[31:1], 1'b0};
    assign w_unused_pc0 = i_flush_pc[0];

    rv_fetch_align_rvc u_rvc (
        .i_c       (w_head),
        .o_instr   (w_exp_instr),
        .o_illegal (w_exp_ill)
    );

    assign w_nxt_instr = w_head_is32 ? r_buf[31:0] : w_exp_instr;
    assign w_nxt_comp  = ~w_head_is32;
    assign w_nxt_ill   = ~w_head_is32 & ((w_head == 16'h0000) | w_exp_ill);
    assign w_pop_bytes = w_head_is32 ? 3'd4 : 3'd2;

    // The first word after a redirect to an odd halfword contributes only its upper half.
    assign w_app_data  = r_skip ? {16'h0000, i_mem_data[31:16]} : i_mem_data;
    assign w_app_n     = r_skip ? 2'd1 : 2'd2;
    assign w_buf_left  = r_buf >> {w_pop, 4'b0000};

    always_comb begin
        w_buf_nxt = w_buf_left;
        w_cnt_nxt = w_cnt_left;
        if (w_accept) begin
            if (w_cnt_left == 2'd0)
                w_buf_nxt = {16'h0000, w_app_data};
            else
                w_buf_nxt = {w_app_data, w_buf_left[15:0]};
            w_cnt_nxt = w_cnt_left + w_app_n;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_buf    <= 48'h0;
            r_hw_cnt <= 2'd0;
            r_skip   <= 1'b0;
        end else if (i_flush) begin
            r_hw_cnt <= 2'd0;
            r_skip   <= i_flush_pc[1];
        end else begin
            r_buf    <= w_buf_nxt;
            r_hw_cnt <= w_cnt_nxt;
            if (w_accept)
                r_skip <= 1'b0;
        end
    end
`else
    logic [31:0] r_word;
    logic        r_full;
    logic [1:0]  w_unused_pc_lsb;

    assign w_avail         = r_full;
    assign o_mem_ready     = ~i_reset & ~i_flush & (~r_full | w_load);
    assign w_accept        = i_mem_valid & o_mem_ready;
    assign w_flush_head    = {i_flush_pc[31:2], 2'b00};
    assign w_unused_pc_lsb = i_flush_pc[1:0];

    assign w_nxt_instr = r_word;
    assign w_nxt_comp  = 1'b0;
    assign w_nxt_ill   = ~&r_word[1:0];
    assign w_pop_bytes = 3'd4;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_word <= 32'h0;
            r_full <= 1'b0;
        end else if (i_flush) begin
            r_full <= 1'b0;
        end else begin
            r_full <= w_accept | (r_full & ~w_load);
            if (w_accept)
                r_word <= i_mem_data;
        end
    end
`endif

    // Output register only advances when empty or being consumed, so a stalled
    // consumer sees stable values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_fetch_addr <= 32'h0;
            r_head_pc    <= 32'h0;
            r_out_valid  <= 1'b0;
            r_out_instr  <= 32'h0;
            r_out_pc     <= 32'h0;
            r_out_comp   <= 1'b0;
            r_out_ill    <= 1'b0;
        end else if (i_flush) begin
            r_fetch_addr <= {i_flush_pc[31:2], 2'b00};
            r_head_pc    <= w_flush_head;
            r_out_valid  <= 1'b0;
        end else begin
            if (w_accept)
                r_fetch_addr <= r_fetch_addr + 32'd4;
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_instr <= w_nxt_instr;
                r_out_pc    <= r_head_pc;
                r_out_comp  <= w_nxt_comp;
                r_out_ill   <= w_nxt_ill;
                r_head_pc   <= r_head_pc + {29'd0, w_pop_bytes};
            end else if (i_instr_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign o_fetch_addr    = r_fetch_addr;
    assign o_instr_valid   = r_out_valid;
    assign o_instr         = r_out_instr;
    assign o_instr_pc      = r_out_pc;
    assign o_instr_comp    = r_out_comp;
    assign o_instr_illegal = r_out_ill;
endmodule

`default_nettype wire

// File: tb/tb_rv_fetch_align.sv
//==============================================================================
// Module      : tb_rv_fetch_align
// Description : Self-checking bench for rv_fetch_align (both RV_EXT_C_EN builds).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_rv_fetch_align;
    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_flush = 1'b0;
    logic [31:0] i_flush_pc = 32'h0;
    logic [31:0] o_fetch_addr;
    logic        i_mem_valid = 1'b0;
    logic [31:0] i_mem_data = 32'h0;
    logic        o_mem_ready;
    logic        o_instr_valid;
    logic        i_instr_ready = 1'b1;
    logic [31:0] o_instr;
    logic [31:0] o_instr_pc;
    logic        o_instr_comp;
    logic        o_instr_illegal;

    always #5 clk = ~clk;

    rv_fetch_align dut (
        .i_clk           (clk),
        .i_reset         (i_reset),
        .i_flush         (i_flush),
        .i_flush_pc      (i_flush_pc),
        .o_fetch_addr    (o_fetch_addr),
        .i_mem_valid     (i_mem_valid),
        .i_mem_data      (i_mem_data),
        .o_mem_ready     (o_mem_ready),
        .o_instr_valid   (o_instr_valid),
        .i_instr_ready   (i_instr_ready),
        .o_instr         (o_instr),
        .o_instr_pc      (o_instr_pc),
        .o_instr_comp    (o_instr_comp),
        .o_instr_illegal (o_instr_illegal)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        comp;
        logic        ill;
    } out_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [1:0]  nw;
        logic [1:0]  ne;
        logic [95:0] ei;
        logic [95:0] ep;
        logic [2:0]  ec;
        logic [2:0]  el;
    } vec_t;

    out_t exp_q[$];
    vec_t tbl[8];
    int   nv = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic last_acc = 1'b0;

    function automatic vec_t mkv(input logic [31:0] pc, input logic [31:0] w0, input logic [31:0] w1,
                                 input logic [1:0] nw, input logic [1:0] ne,
                                 input logic [95:0] ei, input logic [95:0] ep,
                                 input logic [2:0] ec, input logic [2:0] el);
        vec_t v;
        v.pc = pc; v.w0 = w0; v.w1 = w1; v.nw = nw; v.ne = ne;
        v.ei = ei; v.ep = ep; v.ec = ec; v.el = el;
        return v;
    endfunction

    task automatic chk(input string name, input logic [97:0] act, input logic [97:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc, input logic comp, input logic ill);
        out_t e;
        e.instr = instr; e.pc = pc; e.comp = comp; e.ill = ill;
        exp_q.push_back(e);
    endtask

    task automatic check_out();
        out_t e;
        out_t act;
        n_checks++;
        act = {o_instr, o_instr_pc, o_instr_comp, o_instr_illegal};
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_instr: got pc=%h instr=%h, required no output", o_instr_pc, o_instr);
        end else begin
            e = exp_q.pop_front();
            // Expanded form of an illegal halfword is not defined; only its flags are checked.
            if (e.comp && e.ill)
                act.instr = e.instr;
            if (act !== e) begin
                n_errors++;
                $display("FAIL instr_out: got instr=%h pc=%h comp=%0d ill=%0d, required instr=%h pc=%h comp=%0d ill=%0d",
                         o_instr, o_instr_pc, o_instr_comp, o_instr_illegal, e.instr, e.pc, e.comp, e.ill);
            end
        end
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic tick();
        #1;
        if (!i_flush && !i_reset && o_instr_valid && i_instr_ready)
            check_out();
        last_acc = i_mem_valid && o_mem_ready;
        @(negedge clk);
    endtask

    task automatic feed(input logic [31:0] w);
        logic ok;
        ok = 1'b0;
        i_mem_valid = 1'b1;
        i_mem_data  = w;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (last_acc) begin
                ok = 1'b1;
                break;
            end
        end
        i_mem_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL feed_timeout: got no accept of %h, required accept within 40 cycles", w);
        end
    endtask

    task automatic drain();
        i_instr_ready = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if (exp_q.size() == 0)
                break;
            tick();
        end
        chk("drain_pending", 98'(exp_q.size()), 98'd0);
        exp_q.delete();
        for (int k = 0; k < 4; k++)
            tick();
    endtask

    task automatic do_flush(input logic [31:0] pc);
        i_flush    = 1'b1;
        i_flush_pc = pc;
        tick();
        i_flush = 1'b0;
        #1;
        chk("flush_fetch_addr", 98'(o_fetch_addr), 98'({pc[31:2], 2'b00}));
        chk("flush_valid", 98'(o_instr_valid), 98'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [97:0] snap;
`ifdef RV_EXT_C_EN
        tbl[0] = mkv(32'h100, 32'h00A00093, 32'h00B00113, 2'd2, 2'd2,
                     {32'h0, 32'h00B00113, 32'h00A00093}, {32'h0, 32'h104, 32'h100}, 3'b000, 3'b000);
        tbl[1] = mkv(32'h200, 32'h45014505, 32'h0, 2'd1, 2'd2,
                     {32'h0, 32'h00000513, 32'h00100513}, {32'h0, 32'h202, 32'h200}, 3'b011, 3'b000);
        tbl[2] = mkv(32'h400, 32'h00000000, 32'h0, 2'd1, 2'd2,
                     {32'h0, 32'h0, 32'h0}, {32'h0, 32'h402, 32'h400}, 3'b011, 3'b011);
        tbl[3] = mkv(32'h500, 32'h00934505, 32'h456100A0, 2'd2, 2'd3,
                     {32'h01800513, 32'h00A00093, 32'h00100513}, {32'h506, 32'h502, 32'h500}, 3'b101, 3'b000);
        tbl[4] = mkv(32'h600, 32'h8082852E, 32'h0, 2'd1, 2'd2,
                     {32'h0, 32'h00008067, 32'h00B00533}, {32'h0, 32'h602, 32'h600}, 3'b011, 3'b000);
        tbl[5] = mkv(32'h700, 32'hA00141C8, 32'h0, 2'd1, 2'd2,
                     {32'h0, 32'h0000006F, 32'h0045A503}, {32'h0, 32'h702, 32'h700}, 3'b011, 3'b000);
        tbl[6] = mkv(32'hFFFFFFFC, 32'h00A00093, 32'h00B00113, 2'd2, 2'd2,
                     {32'h0, 32'h00B00113, 32'h00A00093}, {32'h0, 32'h0, 32'hFFFFFFFC}, 3'b000, 3'b000);
        nv = 7;
`else
        tbl[0] = mkv(32'h100, 32'h00A00093, 32'h00B00113, 2'd2, 2'd2,
                     {32'h0, 32'h00B00113, 32'h00A00093}, {32'h0, 32'h104, 32'h100}, 3'b000, 3'b000);
        tbl[1] = mkv(32'h200, 32'h45014505, 32'h0, 2'd1, 2'd1,
                     {32'h0, 32'h0, 32'h45014505}, {32'h0, 32'h0, 32'h200}, 3'b000, 3'b001);
        tbl[2] = mkv(32'h302, 32'h00930000, 32'h000100A0, 2'd2, 2'd2,
                     {32'h0, 32'h000100A0, 32'h00930000}, {32'h0, 32'h304, 32'h300}, 3'b000, 3'b011);
        tbl[3] = mkv(32'h400, 32'h00000000, 32'h0, 2'd1, 2'd1,
                     {32'h0, 32'h0, 32'h00000000}, {32'h0, 32'h0, 32'h400}, 3'b000, 3'b001);
        tbl[4] = mkv(32'h600, 32'h8082852E, 32'h00C00193, 2'd2, 2'd2,
                     {32'h0, 32'h00C00193, 32'h8082852E}, {32'h0, 32'h604, 32'h600}, 3'b000, 3'b001);
        tbl[5] = mkv(32'hFFFFFFFC, 32'h00A00093, 32'h00B00113, 2'd2, 2'd2,
                     {32'h0, 32'h00B00113, 32'h00A00093}, {32'h0, 32'h0, 32'hFFFFFFFC}, 3'b000, 3'b000);
        nv = 6;
`endif

        // Reset overrides a simultaneous flush and memory transfer.
        i_reset = 1'b1; i_flush = 1'b1; i_flush_pc = 32'h1234; i_mem_valid = 1'b1; i_mem_data = 32'h00A00093;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset_mem_ready", 98'(o_mem_ready), 98'd0);
        chk("reset_outputs", 98'({o_instr_valid, o_instr, o_instr_pc, o_instr_comp, o_instr_illegal}), 98'd0);
        chk("reset_fetch_addr", 98'(o_fetch_addr), 98'd0);
        @(negedge clk);
        i_reset = 1'b0; i_flush = 1'b0; i_mem_valid = 1'b0;
        #1;
        chk("post_reset_mem_ready", 98'(o_mem_ready), 98'd1);
        @(negedge clk);

        for (int v = 0; v < nv; v++) begin
            do_flush(tbl[v].pc);
            for (int k = 0; k < int'(tbl[v].ne); k++)
                push(tbl[v].ei[k*32 +: 32], tbl[v].ep[k*32 +: 32], tbl[v].ec[k], tbl[v].el[k]);
            feed(tbl[v].w0);
            if (tbl[v].nw > 2'd1)
                feed(tbl[v].w1);
            drain();
        end

        // First valid output two cycles after the accepting cycle.
        do_flush(32'hB00);
        push(32'h00A00093, 32'hB00, 1'b0, 1'b0);
        feed(32'h00A00093);
        #1;
        chk("latency_n1_valid", 98'(o_instr_valid), 98'd0);
        @(negedge clk);
        #1;
        chk("latency_n2_valid", 98'(o_instr_valid), 98'd1);
        drain();

        // Consumer stall with a full buffer.
        do_flush(32'h800);
        push(32'h00A00093, 32'h800, 1'b0, 1'b0);
        push(32'h00B00113, 32'h804, 1'b0, 1'b0);
        push(32'h00C00193, 32'h808, 1'b0, 1'b0);
        i_instr_ready = 1'b0;
        feed(32'h00A00093);
        feed(32'h00B00113);
        i_mem_valid = 1'b1;
        i_mem_data  = 32'h00C00193;
        #1;
        snap = 98'({o_instr_valid, o_instr, o_instr_pc, o_instr_comp, o_instr_illegal});
        chk("hold_head", 98'({o_instr_valid, o_instr, o_instr_pc}), 98'({1'b1, 32'h00A00093, 32'h800}));
        for (int k = 0; k < 5; k++) begin
            chk("hold_mem_ready", 98'(o_mem_ready), 98'd0);
            chk("hold_stable", 98'({o_instr_valid, o_instr, o_instr_pc, o_instr_comp, o_instr_illegal}), snap);
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        i_instr_ready = 1'b1;
        feed(32'h00C00193);
        drain();

`ifdef RV_EXT_C_EN
        // 32-bit instruction straddling two words after an odd-halfword redirect.
        do_flush(32'h302);
        feed(32'h00930000);
        for (int k = 0; k < 4; k++)
            tick();
        chk("span_wait_valid", 98'(o_instr_valid), 98'd0);
        push(32'h00A00093, 32'h302, 1'b0, 1'b0);
        push(32'h00000013, 32'h306, 1'b1, 1'b0);
        feed(32'h000100A0);
        drain();
`endif

        // Redirect while a word is being offered: that word is dropped.
        do_flush(32'h900);
        feed(32'h00A00093);
        i_mem_valid = 1'b1;
        i_mem_data  = 32'h11111113;
        i_flush     = 1'b1;
        i_flush_pc  = 32'hA00;
        tick();
        i_flush     = 1'b0;
        i_mem_valid = 1'b0;
        #1;
        chk("midflush_fetch_addr", 98'(o_fetch_addr), 98'h0A00);
        chk("midflush_valid", 98'(o_instr_valid), 98'd0);
        push(32'h00B00113, 32'hA00, 1'b0, 1'b0);
        feed(32'h00B00113);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
